// File: rtl/hex_display_n_if.sv
// hex_display_n_if
//   Bundles the load/convert handshake and the segment bus of hex_display_n.
//   master : the datapath/debug side; drives load, value, lz_blank, blink_mask
//            and observes busy, done, segs.
//   slave  : the display driver itself.
//   Signals:
//     load        capture request, honoured only while busy=0
//     value       DIGITS*4 bits, digit k = value[4k+3:4k], digit 0 rightmost
//     lz_blank    blank leading zero digits, captured together with value
//     blink_mask  per-digit blink enable (only used by blink-enabled builds)
//     busy        conversion in progress
//     done        one-cycle pulse when segs is committed
//     segs        DIGITS*7 bits, digit k = segs[7k+6:7k], order {g,f,e,d,c,b,a}
interface hex_display_n_if #(
    parameter int DIGITS = 4
);
    logic                  load;
    logic [4*DIGITS-1:0]   value;
    logic                  lz_blank;
    logic [DIGITS-1:0]     blink_mask;
    logic                  busy;
    logic                  done;
    logic [7*DIGITS-1:0]   segs;

    modport master (
        output load, value, lz_blank, blink_mask,
        input  busy, done, segs
    );

    modport slave (
        input  load, value, lz_blank, blink_mask,
        output busy, done, segs
    );
endinterface

// File: rtl/hex_display_n.sv
// hex_display_n
//   N-digit hex to 7-segment driver. A load captures the whole value, the
//   digits are decoded one per cycle starting with the most significant one,
//   and all digits are committed to the output register in a single cycle so
//   the display never shows a half-updated number.
//   Ports:
//     clk   single clock, all state changes on posedge
//     rst   synchronous reset, active-high
//     bus   hex_display_n_if.slave (load/value/lz_blank/blink_mask in,
//           busy/done/segs out)
//   Optional feature: define HEX_DISPLAY_BLINK_EN to build a blink divider
//   that blanks the digits selected by blink_mask every other BLINK_DIV
//   cycles. Without it blink_mask is ignored and segs is the committed value.
//
//   state      | meaning
//   -----------+----------------------------------------------------------
//   ST_IDLE    | waiting for load; segs holds the last committed value
//   ST_CONVERT | decoding digit idx into the work buffer, MSD first
//   ST_COMMIT  | copying the work buffer to segs, pulsing done
module hex_display_n #(
    parameter int DIGITS         = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter int BLINK_DIV      = 25_000_000
) (
    input  logic            clk,
    input  logic            rst,
    hex_display_n_if.slave  bus
);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [6:0]       BLANK    = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONVERT,
        ST_COMMIT
    } state_t;

    function automatic logic [6:0] decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return SEG_ACTIVE_LOW ? s : ~s;
    endfunction

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                lead_q, lead_d;
    logic [3:0]          shadow_q [DIGITS];
    logic [3:0]          shadow_d [DIGITS];
    logic [6:0]          work_q [DIGITS];
    logic [6:0]          work_d [DIGITS];
    logic [7*DIGITS-1:0] segs_q, segs_d;
    logic                done_q, done_d;
    logic [3:0]          nibble;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        lead_d   = lead_q;
        shadow_d = shadow_q;
        work_d   = work_q;
        segs_d   = segs_q;
        done_d   = 1'b0;
        nibble   = shadow_q[idx_q];

        case (state_q)
            ST_IDLE: begin
                if (bus.load) begin
                    for (int k = 0; k < DIGITS; k++) begin
                        shadow_d[k] = bus.value[4*k +: 4];
                    end
                    idx_d   = IDX_LAST;
                    lead_d  = bus.lz_blank;
                    state_d = ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                // Digit 0 always decodes, so an all-zero value still shows "0".
                if (lead_q && (nibble == 4'h0) && (idx_q != '0)) begin
                    work_d[idx_q] = BLANK;
                end else begin
                    work_d[idx_q] = decode(nibble);
                    lead_d        = 1'b0;
                end
                if (idx_q == '0) begin
                    state_d = ST_COMMIT;
                end else begin
                    idx_d = idx_q - IDX_ONE;
                end
            end
            ST_COMMIT: begin
                for (int k = 0; k < DIGITS; k++) begin
                    segs_d[7*k +: 7] = work_q[k];
                end
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            lead_q  <= 1'b0;
            segs_q  <= {DIGITS{BLANK}};
            done_q  <= 1'b0;
            for (int k = 0; k < DIGITS; k++) begin
                shadow_q[k] <= 4'h0;
                work_q[k]   <= BLANK;
            end
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            lead_q   <= lead_d;
            segs_q   <= segs_d;
            done_q   <= done_d;
            shadow_q <= shadow_d;
            work_q   <= work_d;
        end
    end

    logic [7*DIGITS-1:0] segs_out;

`ifdef HEX_DISPLAY_BLINK_EN
    localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;

    always_comb begin
        cnt_d   = cnt_q + CNT_ONE;
        phase_d = phase_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    // Gating sits after the committed register so mask changes show at once.
    always_comb begin
        segs_out = segs_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (phase_q && bus.blink_mask[k]) begin
                segs_out[7*k +: 7] = BLANK;
            end
        end
    end
`else
    logic unused_blink_mask;
    assign unused_blink_mask = ^bus.blink_mask;

    always_comb begin
        segs_out = segs_q;
    end
`endif

    assign bus.segs = segs_out;
    assign bus.busy = (state_q != ST_IDLE);
    assign bus.done = done_q;
endmodule

// File: tb/tb_hex_display_n.sv
module tb_hex_display_n;
    localparam int DIGITS = 4;
    localparam logic [27:0] ALL_BLANK = 28'hFFFFFFF;
    localparam logic [6:0]  BLANK7    = 7'b1111111;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hex_display_n_if #(.DIGITS(DIGITS)) bus ();

    hex_display_n #(
        .DIGITS         (DIGITS),
        .SEG_ACTIVE_LOW (1'b1),
        .BLINK_DIV      (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [27:0] exp_q[$];

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    function automatic logic [27:0] model(input logic [15:0] v, input logic lz);
        logic [27:0] r;
        logic        lead;
        logic [3:0]  n;
        r    = '0;
        lead = lz;
        for (int d = DIGITS - 1; d >= 0; d--) begin
            n = v[4*d +: 4];
            if (lead && n == 4'h0 && d != 0) begin
                r[7*d +: 7] = BLANK7;
            end else begin
                r[7*d +: 7] = seg_of(n);
                lead = 1'b0;
            end
        end
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drives a one-cycle load while the DUT is idle and records the expected display.
    task automatic start_load(input logic [15:0] v, input logic lz);
        bus.value    = v;
        bus.lz_blank = lz;
        bus.load     = 1'b1;
        exp_q.push_back(model(v, lz));
        tick();
        bus.load = 1'b0;
    endtask

    // Returns cycles from the load edge to the done pulse (-1 if never seen).
    task automatic wait_done(output int lat, output int busy_cycles);
        lat = -1;
        busy_cycles = 0;
        for (int i = 1; i <= 20; i++) begin
            if (bus.busy === 1'b1) busy_cycles++;
            tick();
            if (bus.done === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.load = 1'b0;
        bus.value = '0;
        bus.lz_blank = 1'b0;
        bus.blink_mask = '0;
        tick();
        tick();
        n_checks++;
        if (bus.segs !== ALL_BLANK) begin
            n_fail++; $display("FAIL reset_segs got %h want %h", bus.segs, ALL_BLANK);
        end
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy);
        end
        n_checks++;
        if (bus.done !== 1'b0) begin
            n_fail++; $display("FAIL reset_done got %b want 0", bus.done);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_convert;
        int lat, bc;
        logic [27:0] exp;
        start_load(16'h1A3F, 1'b0);
        wait_done(lat, bc);
        n_checks++;
        if (lat != 5) begin
            n_fail++; $display("FAIL convert_latency got %0d want 5", lat);
        end
        n_checks++;
        if (bc != 5) begin
            n_fail++; $display("FAIL convert_busy_cycles got %0d want 5", bc);
        end
        exp = exp_q.pop_front();
        n_checks++;
        if (bus.segs !== exp) begin
            n_fail++; $display("FAIL convert_segs got %h want %h", bus.segs, exp);
        end
        n_checks++;
        if (bus.segs !== {7'b1111001, 7'b0001000, 7'b0110000, 7'b0001110}) begin
            n_fail++; $display("FAIL convert_literal got %h want %h", bus.segs,
                               {7'b1111001, 7'b0001000, 7'b0110000, 7'b0001110});
        end
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL convert_busy_after got %b want 0", bus.busy);
        end
        tick();
        n_checks++;
        if (bus.done !== 1'b0) begin
            n_fail++; $display("FAIL convert_done_single got %b want 0", bus.done);
        end
    endtask

    task automatic test_lz_blank;
        logic [15:0] vals [4] = '{16'h00B0, 16'h00B0, 16'h0000, 16'h0F00};
        logic        lzs  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        int lat, bc;
        logic [27:0] exp;
        for (int i = 0; i < 4; i++) begin
            start_load(vals[i], lzs[i]);
            wait_done(lat, bc);
            n_checks++;
            if (lat != 5) begin
                n_fail++; $display("FAIL lz_latency case %0d got %0d want 5", i, lat);
            end
            exp = exp_q.pop_front();
            n_checks++;
            if (bus.segs !== exp) begin
                n_fail++; $display("FAIL lz_segs case %0d got %h want %h", i, bus.segs, exp);
            end
            if (i == 0) begin
                n_checks++;
                if (bus.segs !== {BLANK7, BLANK7, 7'b0000011, 7'b1000000}) begin
                    n_fail++; $display("FAIL lz_00b0_literal got %h want %h", bus.segs,
                                       {BLANK7, BLANK7, 7'b0000011, 7'b1000000});
                end
            end
            if (i == 2) begin
                n_checks++;
                if (bus.segs !== {BLANK7, BLANK7, BLANK7, 7'b1000000}) begin
                    n_fail++; $display("FAIL lz_zero_literal got %h want %h", bus.segs,
                                       {BLANK7, BLANK7, BLANK7, 7'b1000000});
                end
            end
        end
    endtask

    task automatic test_drop;
        int dones;
        logic [27:0] at_done;
        logic [27:0] exp;
        dones = 0;
        at_done = '0;
        start_load(16'h1234, 1'b0);
        bus.value = 16'hFFFF;
        tick();
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (bus.done === 1'b1) begin
                dones++;
                at_done = bus.segs;
            end
            tick();
        end
        n_checks++;
        if (dones != 1) begin
            n_fail++; $display("FAIL drop_done_count got %0d want 1", dones);
        end
        exp = exp_q.pop_front();
        n_checks++;
        if (at_done !== exp) begin
            n_fail++; $display("FAIL drop_segs got %h want %h", at_done, exp);
        end
        n_checks++;
        if (bus.segs !== exp) begin
            n_fail++; $display("FAIL drop_hold got %h want %h", bus.segs, exp);
        end
    endtask

    task automatic test_reset_abort;
        int dones;
        dones = 0;
        bus.value = 16'hFFFF;
        bus.lz_blank = 1'b0;
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        n_checks++;
        if (bus.segs !== ALL_BLANK) begin
            n_fail++; $display("FAIL abort_segs got %h want %h", bus.segs, ALL_BLANK);
        end
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL abort_busy got %b want 0", bus.busy);
        end
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (bus.done === 1'b1) dones++;
            tick();
        end
        n_checks++;
        if (dones != 0) begin
            n_fail++; $display("FAIL abort_no_done got %0d want 0", dones);
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] vals [3] = '{16'hC0DE, 16'h9876, 16'h0005};
        int lat, bc, busy_seen;
        logic [27:0] exp;
        bus.load = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.value = vals[i];
            bus.lz_blank = 1'b1;
            exp_q.push_back(model(vals[i], 1'b1));
            tick();
            n_checks++;
            if (bus.busy !== 1'b1) begin
                n_fail++; $display("FAIL b2b_capture case %0d busy got %b want 1", i, bus.busy);
            end
            // Changes while busy must be ignored.
            bus.value = 16'hDEAD;
            bus.lz_blank = 1'b0;
            wait_done(lat, bc);
            if (i == 2) bus.load = 1'b0;
            n_checks++;
            if (lat != 5) begin
                n_fail++; $display("FAIL b2b_latency case %0d got %0d want 5", i, lat);
            end
            exp = exp_q.pop_front();
            n_checks++;
            if (bus.segs !== exp) begin
                n_fail++; $display("FAIL b2b_segs case %0d got %h want %h", i, bus.segs, exp);
            end
        end
        busy_seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.busy !== 1'b0) busy_seen++;
        end
        n_checks++;
        if (busy_seen != 0) begin
            n_fail++; $display("FAIL b2b_idle_after got %0d busy cycles want 0", busy_seen);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_empty got %0d want 0", exp_q.size());
        end
    endtask

`ifdef HEX_DISPLAY_BLINK_EN
    task automatic test_blink;
        int lat, bc, changes, bad_upper, bad_d0, bad_gap, last_change;
        logic [27:0] exp;
        logic [6:0]  prev;
        bus.blink_mask = 4'b0001;
        start_load(16'h1234, 1'b0);
        wait_done(lat, bc);
        exp = exp_q.pop_front();
        changes = 0; bad_upper = 0; bad_d0 = 0; bad_gap = 0; last_change = -1;
        prev = bus.segs[6:0];
        for (int i = 0; i < 24; i++) begin
            tick();
            if (bus.segs[27:7] !== exp[27:7]) bad_upper++;
            if (bus.segs[6:0] !== 7'b0011001 && bus.segs[6:0] !== BLANK7) bad_d0++;
            if (bus.segs[6:0] !== prev) begin
                if (last_change >= 0 && (i - last_change) != 4) bad_gap++;
                last_change = i;
                changes++;
            end
            prev = bus.segs[6:0];
        end
        n_checks++;
        if (bad_upper != 0) begin
            n_fail++; $display("FAIL blink_upper_steady got %0d bad want 0", bad_upper);
        end
        n_checks++;
        if (bad_d0 != 0) begin
            n_fail++; $display("FAIL blink_d0_values got %0d bad want 0", bad_d0);
        end
        n_checks++;
        if (changes < 5 || bad_gap != 0) begin
            n_fail++; $display("FAIL blink_period got %0d changes %0d bad gaps want >=5 and 0",
                               changes, bad_gap);
        end
        bus.blink_mask = '0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL global_timeout got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.load = 1'b0;
        bus.value = '0;
        bus.lz_blank = 1'b0;
        bus.blink_mask = '0;
        rst = 1'b1;
        test_reset();
        test_convert();
        test_lz_blank();
        test_drop();
        test_reset_abort();
        test_back_to_back();
`ifdef HEX_DISPLAY_BLINK_EN
        test_blink();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
